// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//   Fetch stage of the RISC-V core. Owns the PC, issues instruction-memory
//   requests with a req/ready handshake and writes the IF/ID pipeline register.
//   A taken branch from EX redirects the PC and flushes IF/ID. A stall from the
//   hazard unit holds IF/ID and the PC. A response that arrives during a stall
//   is parked in a one-entry hold buffer, so no fetched word is lost or
//   duplicated.
//
//   Optional feature: define FETCH_PERF_CNT_EN to add the perf_fetched_o and
//   perf_stall_o performance counters.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request and word-aligned fetch address (out)
//   imem_ready/rdata  response valid and fetched instruction (in)
//   stall_i           hold IF/ID and PC
//   branch_taken_i    redirect to branch_target_i (low two bits forced to 0)
//   ifid_valid_o      IF/ID holds a real instruction
//   ifid_pc_o         PC of the IF/ID instruction
//   ifid_instr_o      IF/ID instruction
//   opcode_o          ifid_instr_o[6:0], to Control
//   perf_fetched_o    (FETCH_PERF_CNT_EN) valid instructions written to IF/ID
//   perf_stall_o      (FETCH_PERF_CNT_EN) cycles waiting on imem or in HOLD
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
   parameter int unsigned          XLEN      = 32,
   parameter logic [XLEN-1:0]      RESET_PC  = '0,
   parameter logic [XLEN-1:0]      NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall_i,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] branch_target_i,
   output logic            ifid_valid_o,
   output logic [XLEN-1:0] ifid_pc_o,
   output logic [XLEN-1:0] ifid_instr_o,
   output logic [6:0]      opcode_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched_o,
   output logic [31:0]     perf_stall_o
`endif
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t          r_state;
   logic            r_active;     // low only during the first cycle after reset release
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_buf_instr;  // parked response; its PC is r_pc
   logic            r_ifid_valid;
   logic [XLEN-1:0] r_ifid_pc;
   logic [XLEN-1:0] r_ifid_instr;

   logic            w_ack;
   logic [XLEN-1:0] w_pc_next;
   logic [XLEN-1:0] w_target;

   assign imem_req  = r_active && (r_state == FETCH);
   assign imem_addr = r_pc;
   assign w_ack     = imem_req && imem_ready;
   assign w_pc_next = r_pc + XLEN'(4);
   assign w_target  = branch_target_i & ~XLEN'(3);

   assign ifid_valid_o = r_ifid_valid;
   assign ifid_pc_o    = r_ifid_pc;
   assign ifid_instr_o = r_ifid_instr;
   assign opcode_o     = r_ifid_instr[6:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= FETCH;
         r_active     <= 1'b0;
         r_pc         <= RESET_PC;
         r_buf_instr  <= '0;
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= '0;
         r_ifid_instr <= NOP_INSTR;
      end else begin
         r_active <= 1'b1;
         if (branch_taken_i) begin
            // Redirect wins over stall and ready; any same-cycle response is dropped.
            r_pc         <= w_target;
            r_state      <= FETCH;
            r_buf_instr  <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
         end else begin
            unique case (r_state)
               FETCH: begin
                  if (w_ack) begin
                     if (!stall_i) begin
                        r_ifid_valid <= 1'b1;
                        r_ifid_pc    <= r_pc;
                        r_ifid_instr <= imem_rdata;
                        r_pc         <= w_pc_next;
                     end else begin
                        r_buf_instr <= imem_rdata;
                        r_state     <= HOLD;
                     end
                  end else if (!stall_i) begin
                     // Bubble while waiting; ifid_pc is left as is.
                     r_ifid_valid <= 1'b0;
                     r_ifid_instr <= NOP_INSTR;
                  end
               end
               HOLD: begin
                  if (!stall_i) begin
                     r_ifid_valid <= 1'b1;
                     r_ifid_pc    <= r_pc;
                     r_ifid_instr <= r_buf_instr;
                     r_buf_instr  <= '0;
                     r_pc         <= w_pc_next;
                     r_state      <= FETCH;
                  end
               end
               default: r_state <= FETCH;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_stall;
   logic        w_wr_valid;
   logic        w_stall_cyc;

   assign w_wr_valid  = !branch_taken_i && !stall_i &&
                        (((r_state == FETCH) && w_ack) || (r_state == HOLD));
   assign w_stall_cyc = (imem_req && !imem_ready) || (r_state == HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetched <= '0;
         r_perf_stall   <= '0;
      end else begin
         if (w_wr_valid)  r_perf_fetched <= r_perf_fetched + 32'd1;
         if (w_stall_cyc) r_perf_stall   <= r_perf_stall + 32'd1;
      end
   end

   assign perf_fetched_o = r_perf_fetched;
   assign perf_stall_o   = r_perf_stall;
`endif

endmodule
